axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter aw_t, default logic, AW channel payload struct type; passed through unmodified.
REQ-002 Parameter w_t, default logic, W channel payload struct type; field `last` is used, all other fields are passed through unmodified.
REQ-003 Parameter MaxWTrans, default 4, depth of the write-order FIFO (outstanding AW grants awaiting W last); legal range 1..16.
REQ-004 Ports clk_i and rst_ni SHALL be as follows: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-005 Subordinate-side ports, indexed [1:0] by requester:
- slv_aw_valid_i  in  [1:0]  AW valid per requester.
- slv_aw_chan_i  in  aw_t[1:0]  AW payload per requester.
- slv_aw_ready_o  out  [1:0]  AW ready per requester.
- slv_w_valid_i  in  [1:0]  W valid per requester.
- slv_w_chan_i  in  w_t[1:0]  W payload per requester.
- slv_w_ready_o  out  [1:0]  W ready per requester.
REQ-006 Manager-side ports:
- mst_aw_valid_o  out  1  AW valid.
- mst_aw_chan_o  out  aw_t  AW payload.
- mst_aw_ready_i  in  1  AW ready.
- mst_w_valid_o  out  1  W valid.
- mst_w_chan_o  out  w_t  W payload.
- mst_w_ready_i  in  1  W ready.
- w_pending_o  out  $clog2(MaxWTrans+1)  number of granted AWs whose W burst has not completed.

Function
REQ-007 AW arbitration SHALL be round-robin between the two requesters; a priority pointer selects the preferred requester when both are valid.
REQ-008 mst_aw_valid_o SHALL be slv_aw_valid_i[sel] AND NOT fifo_full; mst_aw_chan_o SHALL be slv_aw_chan_i[sel]; slv_aw_ready_o[sel] SHALL be mst_aw_ready_i AND NOT fifo_full; the non-selected slv_aw_ready_o SHALL be 0.
REQ-009 Once mst_aw_valid_o is 1 without mst_aw_ready_i, sel SHALL be locked until the handshake completes (AXI stability), regardless of the other requester.
REQ-010 On each AW handshake the priority pointer SHALL move to the other requester; without a handshake it SHALL hold.
REQ-011 On each AW handshake, the index sel SHALL be pushed into the write-order FIFO.
REQ-012 W routing: with FIFO not empty and head = h, mst_w_valid_o = slv_w_valid_i[h], mst_w_chan_o = slv_w_chan_i[h], slv_w_ready_o[h] = mst_w_ready_i; slv_w_ready_o of the other requester SHALL be 0.
REQ-013 FIFO empty: mst_w_valid_o = 0 and both slv_w_ready_o = 0; no same-cycle bypass (W for an AW granted in cycle n is forwarded from cycle n+1 at earliest).
REQ-014 A W handshake with last = 1 SHALL pop the FIFO head; beats with last = 0 SHALL not change FIFO state.
REQ-015 FIFO full: AW SHALL be blocked even if a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop (not full) SHALL leave occupancy unchanged and preserve order; pointers wrap modulo MaxWTrans.
REQ-017 w_pending_o SHALL equal FIFO occupancy, registered: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-018 Paths valid->ready and ready->valid are combinational; the block SHALL add no cycle of latency on AW or W when not blocked.

Reset
REQ-019 While rst_ni = 0: FIFO empty, w_pending_o = 0, priority pointer = requester 0, AW lock cleared; hence mst_aw_valid_o = 0, mst_w_valid_o = 0, all slv_*_ready_o = 0.
REQ-020 Reset asserted mid-burst SHALL discard all FIFO entries and the lock immediately; after release the block behaves as freshly reset.

Verification
REQ-021 Both requesters assert AW continuously, mst_aw_ready_i = 1, MaxWTrans = 4 -> grants alternate 0,1,0,1; 5th AW blocked with w_pending_o = 4.
REQ-022 Requester 1 sends 3-beat burst, requester 0 a 1-beat burst, AW order 1 then 0 -> mst_w carries 3 beats from requester 1 then 1 beat from requester 0; requester 0 W stalled (ready 0) until requester 1 last completes.
REQ-023 mst_aw_ready_i = 0 for 5 cycles with requester 0 selected, requester 1 becomes valid in cycle 2 -> mst_aw_chan_o stays requester 0 payload until handshake; then requester 1 granted.
REQ-024 FIFO full (4), W last handshake and pending AW in same cycle -> pop only, w_pending_o = 3; AW granted next cycle, w_pending_o back to 4.
REQ-025 AW handshake cycle n with FIFO empty and W valid -> mst_w_valid_o = 0 in cycle n, = 1 in n+1.
REQ-026 rst_ni pulsed low with w_pending_o = 2 mid-burst -> all valids/readies 0, w_pending_o = 0 asynchronously; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter: round-robin AW arbitration with a write-order
// FIFO that steers each W burst to the manager in the order its AW was granted.
module axi_wr_arbiter #(
  parameter type         aw_t      = logic,
  parameter type         w_t       = logic,
  parameter int unsigned MaxWTrans = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [1:0]                       slv_aw_valid_i,
  input  aw_t  [1:0]                       slv_aw_chan_i,
  output logic [1:0]                       slv_aw_ready_o,
  input  logic [1:0]                       slv_w_valid_i,
  input  w_t   [1:0]                       slv_w_chan_i,
  output logic [1:0]                       slv_w_ready_o,
  output logic                             mst_aw_valid_o,
  output aw_t                              mst_aw_chan_o,
  input  logic                             mst_aw_ready_i,
  output logic                             mst_w_valid_o,
  output w_t                               mst_w_chan_o,
  input  logic                             mst_w_ready_i,
  output logic [$clog2(MaxWTrans+1)-1:0]   w_pending_o
);

  localparam int unsigned PtrW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxWTrans + 1);

  logic [MaxWTrans-1:0] order_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 prio_q, lock_q, lock_sel_q;
  logic                 sel, head, fifo_full, fifo_empty;
  logic                 aw_hs, w_hs, w_last, push, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxWTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CntW'(MaxWTrans));
  assign fifo_empty = (cnt_q == '0);
  assign head       = order_q[rd_ptr_q];

  // A stalled AW keeps its requester selected until the handshake completes.
  always_comb begin
    if (lock_q)                sel = lock_sel_q;
    else if (&slv_aw_valid_i)  sel = prio_q;
    else                       sel = slv_aw_valid_i[1];
  end

  // Outputs are forced idle while reset is held, independent of the inputs.
  always_comb begin
    mst_aw_valid_o      = rst_ni & slv_aw_valid_i[sel] & ~fifo_full;
    mst_aw_chan_o       = slv_aw_chan_i[sel];
    slv_aw_ready_o      = '0;
    slv_aw_ready_o[sel] = rst_ni & mst_aw_ready_i & ~fifo_full;
  end

  always_comb begin
    mst_w_valid_o       = ~fifo_empty & slv_w_valid_i[head];
    mst_w_chan_o        = slv_w_chan_i[head];
    slv_w_ready_o       = '0;
    slv_w_ready_o[head] = ~fifo_empty & mst_w_ready_i;
  end

  // A one-bit W payload is treated as the last flag itself.
  if ($bits(w_t) == 1) begin : g_last_bit
    assign w_last = mst_w_chan_o;
  end else begin : g_last_field
    assign w_last = mst_w_chan_o.last;
  end

  assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign w_hs  = mst_w_valid_o & mst_w_ready_i;
  assign push  = aw_hs;
  assign pop   = w_hs & w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      lock_q     <= mst_aw_valid_o & ~mst_aw_ready_i;
      lock_sel_q <= sel;
      if (aw_hs) prio_q <= ~sel;
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) order_q[wr_ptr_q] <= sel;
  end

  assign w_pending_o = cnt_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: per-requester transaction queues drive the
// DUT while a negedge monitor checks it against a queue-based ordering model.
module tb_axi_wr_arbiter;

  typedef struct packed { logic src; logic [14:0] tag; } aw_s;
  typedef struct packed { logic [15:0] data; logic last; } w_s;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready;
  aw_s  [1:0] slv_aw_chan;
  w_s   [1:0] slv_w_chan;
  logic       mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready;
  aw_s        mst_aw_chan;
  w_s         mst_w_chan;
  logic [2:0] w_pending;

  axi_wr_arbiter #(.aw_t(aw_s), .w_t(w_s), .MaxWTrans(MAXW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_chan_i(slv_aw_chan), .slv_aw_ready_o(slv_aw_ready),
    .slv_w_valid_i(slv_w_valid), .slv_w_chan_i(slv_w_chan), .slv_w_ready_o(slv_w_ready),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_chan_o(mst_aw_chan), .mst_aw_ready_i(mst_aw_ready),
    .mst_w_valid_o(mst_w_valid), .mst_w_chan_o(mst_w_chan), .mst_w_ready_i(mst_w_ready),
    .w_pending_o(w_pending)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus-side queues and the monitor's expectation sources
  aw_s  aw_q[2][$];
  w_s   w_q[2][$];
  w_s   exb[2][$];
  int   exl[2][$];
  int   tag_cnt = 0;

  // Reference model: grant order queue, expected W beat stream, pointer and lock
  logic mfifo[$];
  w_s   exw[$];
  logic m_prio = 1'b0;
  logic m_lock = 1'b0;
  logic m_lock_sel = 1'b0;

  int aw_pct, w_pct, ar_pct, wr_pct;
  logic [1:0] aw_done, w_done;

  task automatic gen(input int n);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < n; k++) begin
        int  len;
        aw_s a;
        len = $urandom_range(1, 4);
        a.src = r[0];
        a.tag = tag_cnt[14:0];
        tag_cnt++;
        aw_q[r].push_back(a);
        exl[r].push_back(len);
        for (int b = 0; b < len; b++) begin
          w_s w;
          w.data = 16'($urandom);
          w.last = (b == len - 1);
          w_q[r].push_back(w);
          exb[r].push_back(w);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    aw_done = slv_aw_valid & slv_aw_ready;
    w_done  = slv_w_valid & slv_w_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (aw_done[r]) begin
        void'(aw_q[r].pop_front());
        slv_aw_valid[r] = 1'b0;
      end
      if (w_done[r]) begin
        void'(w_q[r].pop_front());
        slv_w_valid[r] = 1'b0;
      end
      if (!slv_aw_valid[r] && aw_q[r].size() > 0 && int'($urandom_range(99)) < aw_pct) begin
        slv_aw_valid[r] = 1'b1;
        slv_aw_chan[r]  = aw_q[r][0];
      end
      if (!slv_w_valid[r] && w_q[r].size() > 0 && int'($urandom_range(99)) < w_pct) begin
        slv_w_valid[r] = 1'b1;
        slv_w_chan[r]  = w_q[r][0];
      end
    end
    mst_aw_ready = int'($urandom_range(99)) < ar_pct;
    mst_w_ready  = int'($urandom_range(99)) < wr_pct;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pct(input int a, input int w, input int ar, input int wr);
    aw_pct = a; w_pct = w; ar_pct = ar; wr_pct = wr;
  endtask

  task automatic clear_drv();
    for (int r = 0; r < 2; r++) begin
      aw_q[r].delete();
      w_q[r].delete();
    end
    slv_aw_valid = '0;
    slv_w_valid  = '0;
    aw_done      = '0;
    w_done       = '0;
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    logic       full, any, es, h;
    logic [1:0] er;
    w_s         e;
    int         len;
    if (!rst_n) begin
      chk("rst_aw_valid", {31'd0, mst_aw_valid}, 32'd0);
      chk("rst_w_valid", {31'd0, mst_w_valid}, 32'd0);
      chk("rst_aw_ready", {30'd0, slv_aw_ready}, 32'd0);
      chk("rst_w_ready", {30'd0, slv_w_ready}, 32'd0);
      chk("rst_pending", {29'd0, w_pending}, 32'd0);
      mfifo.delete();
      exw.delete();
      for (int r = 0; r < 2; r++) begin
        exb[r].delete();
        exl[r].delete();
      end
      m_prio = 1'b0;
      m_lock = 1'b0;
    end else begin
      full = (mfifo.size() == MAXW);
      any  = |slv_aw_valid;
      if (m_lock)              es = m_lock_sel;
      else if (&slv_aw_valid)  es = m_prio;
      else                     es = slv_aw_valid[1];
      chk("pending", {29'd0, w_pending}, mfifo.size());
      chk("aw_valid", {31'd0, mst_aw_valid}, {31'd0, any && !full});
      if (any) begin
        chk("aw_chan", {16'd0, mst_aw_chan}, {16'd0, slv_aw_chan[es]});
        er = (mst_aw_ready && !full) ? (2'b01 << es) : 2'b00;
        chk("aw_ready", {30'd0, slv_aw_ready}, {30'd0, er});
      end
      if (mfifo.size() == 0) begin
        chk("w_valid_empty", {31'd0, mst_w_valid}, 32'd0);
        chk("w_ready_empty", {30'd0, slv_w_ready}, 32'd0);
      end else begin
        h  = mfifo[0];
        er = mst_w_ready ? (2'b01 << h) : 2'b00;
        chk("w_valid", {31'd0, mst_w_valid}, {31'd0, slv_w_valid[h]});
        chk("w_ready", {30'd0, slv_w_ready}, {30'd0, er});
      end
      if (mst_w_valid && mst_w_ready) begin
        if (exw.size() == 0) begin
          chk("w_unexpected", 32'd1, 32'd0);
        end else begin
          e = exw.pop_front();
          chk("w_chan", {15'd0, mst_w_chan}, {15'd0, e});
          if (e.last && mfifo.size() > 0) void'(mfifo.pop_front());
        end
      end
      if (mst_aw_valid && mst_aw_ready) begin
        mfifo.push_back(es);
        if (exl[es].size() > 0) begin
          len = exl[es].pop_front();
          for (int b = 0; b < len; b++) exw.push_back(exb[es].pop_front());
        end
        m_prio = ~es;
        m_lock = 1'b0;
      end else if (mst_aw_valid) begin
        m_lock     = 1'b1;
        m_lock_sel = es;
      end else begin
        m_lock = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    rst_n        = 1'b0;
    slv_aw_valid = 2'b11;
    slv_w_valid  = 2'b11;
    slv_aw_chan  = '0;
    slv_w_chan   = '0;
    mst_aw_ready = 1'b1;
    mst_w_ready  = 1'b1;
    aw_done      = '0;
    w_done       = '0;
    set_pct(100, 100, 100, 0);
    #1;
    chk("init_aw_ready", {30'd0, slv_aw_ready}, 32'd0);
    chk("init_aw_valid", {31'd0, mst_aw_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clear_drv();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous AW from both sides with W held off: alternation then full block
    gen(6);
    run(12);

    set_pct(60, 70, 50, 50);
    gen(200);
    run(1500);

    // Long AW stalls to exercise the selection lock
    set_pct(80, 70, 15, 60);
    run(300);

    // Drain W until idle, then build up exactly two pending grants
    set_pct(100, 100, 0, 100);
    cyc = 0;
    while (w_pending != 0 && cyc < 500) begin step(); cyc++; end
    if (cyc >= 500) chk("drain_timeout", 32'd1, 32'd0);
    gen(10);
    set_pct(100, 100, 100, 0);
    cyc = 0;
    while (w_pending != 3'd2 && cyc < 50) begin step(); cyc++; end
    chk("pending_before_rst", {29'd0, w_pending}, 32'd2);

    // Asynchronous reset mid-burst with inputs still active
    #2;
    slv_aw_valid = 2'b11;
    slv_w_valid  = 2'b11;
    mst_aw_ready = 1'b1;
    mst_w_ready  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_pending", {29'd0, w_pending}, 32'd0);
    chk("arst_aw_valid", {31'd0, mst_aw_valid}, 32'd0);
    chk("arst_w_valid", {31'd0, mst_w_valid}, 32'd0);
    chk("arst_aw_ready", {30'd0, slv_aw_ready}, 32'd0);
    chk("arst_w_ready", {30'd0, slv_w_ready}, 32'd0);
    clear_drv();
    @(negedge clk);
    @(posedge clk);
    #1;
    gen(60);
    slv_aw_valid   = 2'b11;
    slv_aw_chan[0] = aw_q[0][0];
    slv_aw_chan[1] = aw_q[1][0];
    mst_aw_ready   = 1'b1;
    mst_w_ready    = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first_grant_src", {31'd0, mst_aw_chan.src}, 32'd0);

    set_pct(70, 60, 60, 40);
    run(600);

    // Final drain
    set_pct(100, 100, 100, 100);
    cyc = 0;
    while ((aw_q[0].size() + aw_q[1].size() + w_q[0].size() + w_q[1].size() != 0
            || w_pending != 0) && cyc < 3000) begin
      step();
      cyc++;
    end
    if (cyc >= 3000) chk("final_drain_timeout", 32'd1, 32'd0);
    run(3);
    chk("end_pending", {29'd0, w_pending}, 32'd0);
    chk("end_exp_empty", exw.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
